featuremap_conv3x3_mc: RTL and testbench
========================================

# featuremap_conv3x3_mc

Parametrised multi-channel 3x3 convolution stage for the layer-1 feature-map path. It accepts a raster stream of padded pixels, where each beat carries all input channels. It keeps two line buffers per channel, forms the 3x3 window, and multiply-accumulates across every channel. It then adds a runtime-loaded bias and streams out one rounded, saturated fixed-point feature value per valid window, with valid/ready backpressure on both sides.

## Interface
- DATA_WIDTH, 16: signed fixed-point sample, weight and bias width.
- FRAC_BITS, 8: fractional bits of every DATA_WIDTH quantity (Q8.8 default).
- CHANNELS, 3: input channels per pixel.
- IMG_WIDTH, 34: padded row length in pixels, 3 or more.
- IMG_HEIGHT, 34: padded rows per frame, 3 or more.
- ACC_WIDTH, 2*DATA_WIDTH+8: accumulator width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH*CHANNELS  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- w_wren  in  1  weight/bias write strobe.
- w_addr  in  $clog2(CHANNELS*9+1)  address c*9+k (k = 3*row+col) selects a weight; CHANNELS*9 selects the bias.
- w_data  in  DATA_WIDTH  value written.
- out_data  out  DATA_WIDTH  feature value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- frame_done  out  1  one-cycle pulse, frame complete.
- busy  out  1  state != IDLE.

## Operation
- Weight and bias registers reset to 0. A write is visible to products computed from the next cycle on. Writes to addresses above CHANNELS*9 are ignored. Writes are legal at any time.
- col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1. Both advance only on an accepted pixel; col wraps to 0 and increments row.
- Per channel, two line buffers of depth IMG_WIDTH plus a 3x3 shift window.
- A window is valid when the pixel accepted at position (row, col) has row>=2 and col>=2. Each frame produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs in raster order.
- Stage 1 computes all 9*CHANNELS products at full 2*DATA_WIDTH signed width.
- Stage 2 sign-extends the products to ACC_WIDTH, sums them, and adds bias<<<FRAC_BITS.
- Stage 3 adds 1<<(FRAC_BITS-1), shifts the result arithmetically right by FRAC_BITS, and saturates to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- FSM:
  - IDLE: goes to FILL on the first accepted pixel.
  - FILL: rows 0-1; goes to RUN when row becomes 2.
  - RUN: goes to DRAIN when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
  - DRAIN: goes to IDLE when the frame's last output handshakes. That same cycle frame_done=1.
- in_ready = en && state != DRAIN. No pixel of the next frame is taken until the current frame has drained.
- Reset mid-frame clears the counters, line-buffer pointers, pipeline valids, weights and bias, and returns the FSM to IDLE. Partial outputs are discarded. Line-buffer RAM contents need not be cleared.

## Timing
- Reset values:
  - in_ready=0 while rst is low, then 1.
  - out_valid=0, out_data=0, frame_done=0, busy=0.
- Global enable: en = !(out_valid && !out_ready). All pipeline registers, the window, the counters and the line buffers advance only when en=1.
- Latency: the pixel that completes a window is accepted at edge t. out_valid rises after edge t+3, assuming no stall.
- Throughput: one pixel per cycle, and one output per cycle in RUN.
- Under a stall, out_data is held stable until the handshake. Nothing is dropped or duplicated.
- A simultaneous stall release and new input are handled by the same en. in_ready is combinational from out_valid/out_ready.

## Configuration
- FEATUREMAP_RELU_EN defined: stage 3 forces any negative saturated result to 0.
- FEATUREMAP_RELU_EN undefined: signed result passes unchanged.
- Latency is identical in both builds.

## Structure
- Shared package featuremap_pkg holds:
  - the localparams WIN_TAPS=9 and BIAS_ADDR function of CHANNELS;
  - saturation-bound constants;
  - the FSM state typedef (IDLE, FILL, RUN, DRAIN).
- One sub-module, featuremap_linebuf: two-row delay line for one channel. It exposes the three column taps and is instantiated CHANNELS times under a generate loop.

## Test plan
- CHANNELS=3, 5x5 frame, all weights 0x0100, bias 0, all pixels 0x0100 -> nine outputs of 0x1B00, then frame_done pulses once and busy drops.
- Only ch0 k4 = 0x0100, pixel value (5*row+col)<<8 -> outputs 6,7,8,11,12,13,16,17,18 (each <<8), in order.
- All weights and pixels 0x7FFF -> 0x7FFF. Weights 0x8000 with pixels 0x7FFF -> 0x8000, or 0x0000 with FEATUREMAP_RELU_EN.
- Weights 0, bias 0xFF80 -> every output 0xFF80, or 0x0000 with FEATUREMAP_RELU_EN.
- out_ready low for 10 cycles mid-frame -> in_ready low the same cycles, out_data held. The output sequence is identical to the unstalled run.
- rst low after 12 pixels -> all outputs at reset values and busy=0. After reloading weights, a fresh frame reproduces the first scenario exactly.

Source files
------------

// File: rtl/featuremap_pkg.sv
// Shared definitions for the multi-channel 3x3 feature-map convolution stage:
// window geometry, coefficient address map, saturation bounds and FSM states.
package featuremap_pkg;

    // Taps in one 3x3 window; tap k = 3*row + col.
    localparam int WIN_TAPS = 9;

    // Address of the bias register: it sits just past the last channel's weights.
    function automatic int bias_addr(input int channels);
        return channels * WIN_TAPS;
    endfunction

    // Largest value representable in a signed field of width dw.
    function automatic longint sat_hi(input int dw);
        return (longint'(1) <<< (dw - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed field of width dw.
    function automatic longint sat_lo(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    // Frame sequencing states, kept as plain 2-bit constants.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t FILL  = 2'd1;
    localparam state_t RUN   = 2'd2;
    localparam state_t DRAIN = 2'd3;

endpackage

// File: rtl/featuremap_linebuf.sv
// Two-row delay line for one channel. The three column taps are the pixel
// two rows above, one row above and the incoming pixel, all at the same column.
// Row storage is not reset; only the write pointer is.
module featuremap_linebuf #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_pix,
    output logic [DATA_WIDTH-1:0] o_tap_top,
    output logic [DATA_WIDTH-1:0] o_tap_mid,
    output logic [DATA_WIDTH-1:0] o_tap_bot
);

    localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_row1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_row2 [IMG_WIDTH];
    logic [PW-1:0]         r_ptr;

    // Circular column pointer, advances once per accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_shift) begin
            r_ptr <= (r_ptr == PW'(IMG_WIDTH - 1)) ? '0 : r_ptr + PW'(1);
        end
    end

    // Push the new pixel into row 1 and move row 1's old value into row 2.
    always_ff @(posedge clk) begin
        if (i_shift) begin
            r_row1[r_ptr] <= i_pix;
            r_row2[r_ptr] <= r_row1[r_ptr];
        end
    end

    assign o_tap_bot = i_pix;
    assign o_tap_mid = r_row1[r_ptr];
    assign o_tap_top = r_row2[r_ptr];

endmodule

// File: rtl/featuremap_conv3x3_mc.sv
// Multi-channel 3x3 convolution with bias, rounding and saturation.
// Pipeline: window register -> products -> accumulate+bias -> round/saturate/output.
// Build option: define FEATUREMAP_RELU_EN to clamp negative results to zero.
module featuremap_conv3x3_mc
    import featuremap_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int CHANNELS   = 3,
    parameter int IMG_WIDTH  = 34,
    parameter int IMG_HEIGHT = 34,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8,
    parameter int ADDR_WIDTH = $clog2(CHANNELS * 9 + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           w_wren,
    input  logic [ADDR_WIDTH-1:0]          w_addr,
    input  logic [DATA_WIDTH-1:0]          w_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int TAPS  = CHANNELS * WIN_TAPS;
    localparam int BADDR = bias_addr(CHANNELS);
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);

    typedef logic signed [DATA_WIDTH-1:0]   data_t;
    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;

    localparam acc_t  SAT_HI  = acc_t'(sat_hi(DATA_WIDTH));
    localparam acc_t  SAT_LO  = acc_t'(sat_lo(DATA_WIDTH));
    localparam data_t SAT_HI_D = data_t'(sat_hi(DATA_WIDTH));
    localparam data_t SAT_LO_D = data_t'(sat_lo(DATA_WIDTH));
    localparam acc_t  ROUND_C = acc_t'(longint'(1) <<< (FRAC_BITS - 1));

    // Coefficients
    data_t r_w [TAPS];
    data_t r_bias;

    // Control
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_en;
    logic          w_accept;
    logic          w_win_fire;
    logic          w_last_pix;
    logic          w_frame_done;

    // Datapath
    logic [DATA_WIDTH-1:0] w_tap_top [CHANNELS];
    logic [DATA_WIDTH-1:0] w_tap_mid [CHANNELS];
    logic [DATA_WIDTH-1:0] w_tap_bot [CHANNELS];
    data_t r_win  [CHANNELS][WIN_TAPS];
    prod_t r_prod [TAPS];
    acc_t  r_acc;
    acc_t  w_sum;
    acc_t  w_rnd;
    acc_t  w_shr;
    data_t w_sat;
    data_t w_res;
    logic  r_s0_valid, r_s0_last;
    logic  r_s1_valid, r_s1_last;
    logic  r_s2_valid, r_s2_last;
    logic  r_out_valid, r_out_last;
    data_t r_out_data;

    // A stalled output freezes everything; new input waits out the drain phase.
    assign w_en       = !(r_out_valid && !out_ready);
    assign in_ready   = rst && w_en && (r_state != DRAIN);
    assign w_accept   = in_valid && in_ready;
    assign w_win_fire = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last_pix = w_accept && (r_row == RW'(IMG_HEIGHT - 1)) && (r_col == CW'(IMG_WIDTH - 1));

    // Weight and bias register file; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_w[i] <= '0;
            end
            r_bias <= '0;
        end else if (w_wren) begin
            if (w_addr < ADDR_WIDTH'(BADDR)) begin
                r_w[w_addr] <= data_t'(w_data);
            end else if (w_addr == ADDR_WIDTH'(BADDR)) begin
                r_bias <= data_t'(w_data);
            end
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == CW'(IMG_WIDTH - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_lb
            featuremap_linebuf #(
                .DATA_WIDTH (DATA_WIDTH),
                .IMG_WIDTH  (IMG_WIDTH)
            ) u_linebuf (
                .clk       (clk),
                .rst       (rst),
                .i_shift   (w_accept),
                .i_pix     (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_tap_top (w_tap_top[g]),
                .o_tap_mid (w_tap_mid[g]),
                .o_tap_bot (w_tap_bot[g])
            );
        end
    endgenerate

    // Shift the 3x3 window left by one column and load the new column on the right.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_win[c][0] <= r_win[c][1];
                r_win[c][1] <= r_win[c][2];
                r_win[c][2] <= data_t'(w_tap_top[c]);
                r_win[c][3] <= r_win[c][4];
                r_win[c][4] <= r_win[c][5];
                r_win[c][5] <= data_t'(w_tap_mid[c]);
                r_win[c][6] <= r_win[c][7];
                r_win[c][7] <= r_win[c][8];
                r_win[c][8] <= data_t'(w_tap_bot[c]);
            end
        end
    end

    // Full-width products of every tap and channel, then the accumulated sum.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < WIN_TAPS; k++) begin
                    r_prod[c*WIN_TAPS + k] <= prod_t'(r_win[c][k]) * prod_t'(r_w[c*WIN_TAPS + k]);
                end
            end
            r_acc <= w_sum;
        end
    end

    // Sign-extended sum of all products plus the bias aligned to the product scale.
    always_comb begin
        w_sum = acc_t'(r_bias) <<< FRAC_BITS;
        for (int i = 0; i < TAPS; i++) begin
            w_sum = w_sum + acc_t'(r_prod[i]);
        end
    end

    // Round to nearest, drop the fractional bits and clamp to the output range.
    always_comb begin
        w_rnd = r_acc + ROUND_C;
        w_shr = w_rnd >>> FRAC_BITS;
        if (w_shr > SAT_HI) begin
            w_sat = SAT_HI_D;
        end else if (w_shr < SAT_LO) begin
            w_sat = SAT_LO_D;
        end else begin
            w_sat = data_t'(w_shr[DATA_WIDTH-1:0]);
        end
`ifdef FEATUREMAP_RELU_EN
        if (w_sat[DATA_WIDTH-1]) begin
            w_res = '0;
        end else begin
            w_res = w_sat;
        end
`else
        w_res = w_sat;
`endif
    end

    // Valid and end-of-frame tags travelling alongside the datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0_valid  <= 1'b0;
            r_s0_last   <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_en) begin
            r_s0_valid  <= w_win_fire;
            r_s0_last   <= w_last_pix;
            r_s1_valid  <= r_s0_valid;
            r_s1_last   <= r_s0_last;
            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_s2_valid;
            r_out_last  <= r_s2_last;
        end
    end

    // Output register; holds its value while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data <= '0;
        end else if (w_en && r_s2_valid) begin
            r_out_data <= w_res;
        end
    end

    // Frame sequencing: fill the line buffers, run, then drain the pipeline.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FILL: begin
                if (w_accept && (r_row == RW'(1)) && (r_col == CW'(IMG_WIDTH - 1))) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            RUN: begin
                if (w_last_pix) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (r_out_valid && out_ready && r_out_last) begin
                    w_state_nxt  = IDLE;
                    w_frame_done = 1'b1;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_done = w_frame_done;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_featuremap_conv3x3_mc.sv
// Self-checking bench for featuremap_conv3x3_mc on a 5x5, 3-channel frame.
// Expected outputs come from a direct arithmetic model of the convolution.
`timescale 1ns/1ps
module tb_featuremap_conv3x3_mc;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int CH = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int AW = $clog2(CH * 9 + 1);
    localparam int NW = CH * 9 + 1;

    logic               clk;
    logic               rst;
    logic [DW*CH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic               w_wren;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_data;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               frame_done;
    logic               busy;

    featuremap_conv3x3_mc #(
        .DATA_WIDTH (DW), .FRAC_BITS (FB), .CHANNELS (CH),
        .IMG_WIDTH  (W),  .IMG_HEIGHT (H)
    ) dut (
        .clk (clk), .rst (rst),
        .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
        .w_wren (w_wren), .w_addr (w_addr), .w_data (w_data),
        .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
        .frame_done (frame_done), .busy (busy)
    );

    // Reference state
    shortint     wt [NW];
    shortint     pix [CH][H][W];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] saved_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_done = 0;
    int          n_stall_obs = 0;
    int          cyc = 0;
    int          bp_mode = 0;
    int          stall_cnt = 0;
    int          first_out_cyc = -1;
    int          acc_cyc [W*H];
    logic        prev_stall;
    logic [15:0] prev_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Convolution at window centre (r-1, c-1), straight from the arithmetic definition.
    function automatic logic [15:0] model_px(input int r, input int c);
        longint acc;
        logic [63:0] bits;
        acc = longint'(wt[CH*9]) * 256;
        for (int ch = 0; ch < CH; ch++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    acc += longint'(wt[ch*9 + i*3 + j]) * longint'(pix[ch][r-2+i][c-2+j]);
        acc = (acc + 128) >>> FB;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef FEATUREMAP_RELU_EN
        if (acc < 0) acc = 0;
`endif
        bits = acc;
        return bits[15:0];
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                exp_q.push_back(model_px(r, c));
    endtask

    task automatic write_w(input int a, input shortint v);
        w_wren = 1'b1;
        w_addr = AW'(a);
        w_data = v;
        @(posedge clk); #1;
        w_wren = 1'b0;
        if (a < NW) wt[a] = v;
    endtask

    task automatic set_all_w(input shortint v, input shortint b);
        for (int a = 0; a < CH*9; a++) write_w(a, v);
        write_w(CH*9, b);
        write_w(31, shortint'(16'h5A5A));
    endtask

    task automatic rand_w();
        for (int a = 0; a < NW; a++) write_w(a, shortint'(int'($urandom_range(0, 1023)) - 512));
    endtask

    task automatic fill_const(input shortint v);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) pix[ch][r][c] = v;
    endtask

    task automatic fill_rand(input int full);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    pix[ch][r][c] = full ? shortint'($urandom_range(0, 65535))
                                         : shortint'(int'($urandom_range(0, 1023)) - 512);
    endtask

    task automatic send_pixels(input int n, input bit gaps);
        bit acc;
        int t;
        for (int idx = 0; idx < n; idx++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            for (int ch = 0; ch < CH; ch++) in_data[ch*DW +: DW] = pix[ch][idx / W][idx % W];
            in_valid = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                check_eq("in_accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            acc_cyc[idx] = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        int prev;
        int t;
        got_q.delete();
        build_expected();
        first_out_cyc = -1;
        prev = n_done;
        send_pixels(W*H, gaps);
        t = 0;
        while (n_done == prev && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_eq({tag, "_done_pulses"}, n_done - prev, 1);
        check_eq({tag, "_busy_idle"}, busy, 0);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    // Backpressure generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (got_q.size() >= 3 && stall_cnt < 10) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: collects handshaken outputs and checks stall behaviour.
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_hold_data", out_data, prev_data);
                    check_eq("stall_hold_valid", out_valid, 1);
                end
                if (out_valid && !out_ready) begin
                    n_stall_obs++;
                    check_eq("stall_in_ready", in_ready, 0);
                end
                if (frame_done) begin
                    n_done++;
                    check_eq("done_on_handshake", out_valid && out_ready, 1);
                end
                if (out_valid && out_ready) got_q.push_back(out_data);
                if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        w_wren = 1'b0; w_addr = '0; w_data = '0;
        for (int a = 0; a < NW; a++) wt[a] = 0;
        #2;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_eq("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Unit weights and pixels: 27 * 1.0 = 27.0
        set_all_w(shortint'(16'h0100), 0);
        fill_const(shortint'(16'h0100));
        run_frame("ones", 0);
        if (got_q.size() > 0) check_eq("ones_value", got_q[0], 16'h1B00);
        check_eq("latency", first_out_cyc - acc_cyc[2*W+2], 3);
        saved_q = got_q;

        // Centre tap of channel 0 only: output equals the centre pixel
        set_all_w(0, 0);
        write_w(4, shortint'(16'h0100));
        fill_rand(1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) pix[0][r][c] = shortint'((5*r + c) << 8);
        run_frame("centre", 0);

        // Positive and negative saturation
        set_all_w(shortint'(16'h7FFF), 0);
        fill_const(shortint'(16'h7FFF));
        run_frame("sat_hi", 0);
        set_all_w(shortint'(16'h8000), 0);
        run_frame("sat_lo", 0);

        // Bias only
        set_all_w(0, shortint'(16'hFF80));
        fill_rand(1);
        run_frame("bias", 0);

        // Ten-cycle stall mid-frame, then the same frame unstalled
        rand_w();
        fill_rand(0);
        bp_mode = 2; stall_cnt = 0; n_stall_obs = 0;
        run_frame("stall", 0);
        check_eq("stall_seen", n_stall_obs > 0, 1);
        bp_mode = 0;
        saved_q.delete();
        saved_q = got_q;
        run_frame("nostall", 0);
        check_eq("stall_vs_free_len", got_q.size(), saved_q.size());
        for (int i = 0; i < got_q.size() && i < saved_q.size(); i++)
            check_eq($sformatf("stall_vs_free%0d", i), saved_q[i], got_q[i]);

        // Reset after 12 pixels, reload, rerun the unit frame
        set_all_w(shortint'(16'h0100), 0);
        fill_const(shortint'(16'h0100));
        run_frame("ones_ref", 0);
        saved_q = got_q;
        send_pixels(12, 0);
        rst = 1'b0;
        #2;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_data", out_data, 0);
        check_eq("mid_rst_frame_done", frame_done, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_eq("mid_rst_release_ready", in_ready, 1);
        @(posedge clk); #1;
        for (int a = 0; a < NW; a++) wt[a] = 0;
        set_all_w(shortint'(16'h0100), 0);
        run_frame("after_rst", 0);
        check_eq("after_rst_len", got_q.size(), saved_q.size());
        for (int i = 0; i < got_q.size() && i < saved_q.size(); i++)
            check_eq($sformatf("after_rst_same%0d", i), got_q[i], saved_q[i]);

        // Random coefficients, data, input gaps and backpressure
        bp_mode = 1;
        for (int f = 0; f < 3; f++) begin
            rand_w();
            fill_rand(f % 2);
            run_frame($sformatf("rand%0d", f), 1);
        end
        bp_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
